data_bus_arbiter: RTL and testbench
===================================

DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles a granted transaction waits for slave_ready_i before forced completion.
REQ-002 Parameter ERR_RDATA, default 32'hDEAD_BEEF: read data returned to a master on timeout.
REQ-003 clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 resetn_i  input  1  asynchronous, active-low reset.
REQ-005 mN_req_i  input  1  master N (N = 0, 1) transaction request; held high with stable fields until mN_ready_o.
REQ-006 mN_we_i  input  1  master N write enable (1 = write, 0 = read).
REQ-007 mN_be_i  input  4  master N byte enables.
REQ-008 mN_addr_i  input  32  master N byte address.
REQ-009 mN_wd_i  input  32  master N write data.
REQ-010 mN_rd_o  output  32  master N read data; valid only while mN_ready_o = 1.
REQ-011 mN_ready_o  output  1  master N transaction complete, one-cycle pulse.
REQ-012 mN_err_o  output  1  master N transaction ended by timeout; pulses together with mN_ready_o.
REQ-013 slave_req_o  output  1  request to the shared data memory.
REQ-014 slave_we_o / slave_be_o / slave_addr_o / slave_wd_o  output  1/4/32/32  granted master's fields forwarded to the slave.
REQ-015 slave_rd_i  input  32  slave read data.
REQ-016 slave_ready_i  input  1  slave completion; meaningful only while slave_req_o = 1.
REQ-017 grant_o  output  2  one-hot current owner (bit N = master N); 2'b00 when idle.

Function
REQ-018 FSM states: IDLE, BUSY_M0, BUSY_M1.
REQ-019 In IDLE with exactly one mN_req_i high, the next state is BUSY_MN.
REQ-020 In IDLE with both requests high, the master selected by the round-robin pointer wins.
REQ-021 The pointer then favours the other master.
REQ-022 In IDLE with no request, the state stays IDLE and the pointer is unchanged.
REQ-023 Arbitration is registered: a request sampled at edge k gives slave_req_o = 1 in cycle k+1.
REQ-024 In BUSY_MN, slave_req_o = 1 and the slave_* fields are combinationally muxed from master N; grant_o bit N = 1.
REQ-025 In BUSY_MN, the non-granted master sees ready = 0, err = 0 and rd = 0, and its request stays pending.
REQ-026 Completion: in a cycle where BUSY_MN and slave_ready_i = 1, mN_ready_o = 1 and mN_rd_o = slave_rd_i in the same cycle (combinational); the next state is IDLE.
REQ-027 Minimum transaction time: 2 cycles from request to ready, plus 1 idle cycle between back-to-back grants.
REQ-028 Watchdog counter: 0 on entry to BUSY_*; +1 each BUSY cycle without slave_ready_i.
REQ-029 When the watchdog reaches TIMEOUT_CYCLES-1 without slave_ready_i, the arbiter pulses mN_ready_o and mN_err_o, drives mN_rd_o = ERR_RDATA and returns to IDLE.
REQ-030 If slave_ready_i and the timeout fall in the same cycle, slave_ready_i wins: err = 0 and real data is returned.
REQ-031 The watchdog counter saturates and never wraps.
REQ-032 A master holding mN_req_i high after its ready pulse is treated as a new request in IDLE.
REQ-033 mN_req_i dropping during BUSY_MN (protocol violation) does not abort the transaction.
REQ-034 Writes complete identically to reads; mN_rd_o content on writes is don't-care.

Reset
REQ-035 While resetn_i = 0: state IDLE, pointer favours M0, watchdog 0.
REQ-036 While resetn_i = 0: slave_req_o = 0, grant_o = 0, all mN_ready_o / mN_err_o = 0, all mN_rd_o = 0.
REQ-037 Reset assertion mid-transaction drops slave_req_o asynchronously, with no ready pulse to either master.
REQ-038 The first grant after reset release occurs no earlier than the first rising edge with resetn_i = 1.

Structure
REQ-039 Package data_bus_arbiter_pkg holds the state enum, the default TIMEOUT_CYCLES and the default ERR_RDATA.
REQ-040 The watchdog is a sub-module, bus_watchdog (clear, enable, expired), reset by the same resetn_i.
REQ-041 The datapath is a 2:1 mux with no data registers on the slave path.

Verification
REQ-042 m0 read addr 0x100 alone, slave ready 1 cycle after slave_req_o with rd 0x12345678 -> m0_ready_o 1 pulse, m0_rd_o 0x12345678, grant_o 2'b01, m1 silent.
REQ-043 m0 and m1 request the same cycle after reset, both held -> m0 served first, then m1, then m0 again; grant_o 01,00,10,00,01.
REQ-044 m1 write be 4'b0011 addr 0x204 wd 0xAABBCCDD -> slave sees identical fields; m1_ready_o pulses on slave_ready_i.
REQ-045 Slave never ready, TIMEOUT_CYCLES = 8 -> m0_ready_o and m0_err_o pulse together in the 8th BUSY cycle, m0_rd_o 0xDEADBEEF, then IDLE.
REQ-046 slave_ready_i coincides with the timeout cycle -> err 0, real data returned.
REQ-047 resetn_i low mid-BUSY_M1 -> slave_req_o 0 immediately, no ready pulse; after release m0 wins a simultaneous request.

Source files
------------

// File: rtl/data_bus_arbiter_pkg.sv
// Shared types and defaults for the two-master data bus arbiter.
package data_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_M0 = 2'd1,
        BUSY_M1 = 2'd2
    } arb_state_t;

    localparam int          DEFAULT_TIMEOUT_CYCLES = 255;
    localparam logic [31:0] DEFAULT_ERR_RDATA      = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_watchdog.sv
// Saturating cycle counter that flags a transaction stuck waiting on the slave.
module bus_watchdog
    import data_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Wide enough to hold TIMEOUT_CYCLES-1, which is the highest value ever reached.
    localparam int           CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Count waiting cycles, holding at the limit instead of wrapping.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter sharing one data memory port between two masters,
// with a watchdog that force-completes transactions the slave never answers.
module data_bus_arbiter
    import data_bus_arbiter_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
    input  logic        clk_i,
    input  logic        resetn_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wd_i,
    output logic [31:0] m0_rd_o,
    output logic        m0_ready_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wd_i,
    output logic [31:0] m1_rd_o,
    output logic        m1_ready_o,
    output logic        m1_err_o,

    output logic        slave_req_o,
    output logic        slave_we_o,
    output logic [3:0]  slave_be_o,
    output logic [31:0] slave_addr_o,
    output logic [31:0] slave_wd_o,
    input  logic [31:0] slave_rd_i,
    input  logic        slave_ready_i,

    output logic [1:0]  grant_o
);

    arb_state_t  state;
    logic        favour_m1;
    logic        busy;
    logic        expired;
    logic        txn_done;
    logic        timed_out;
    logic [31:0] resp_rd;

    assign busy      = (state != IDLE);
    assign txn_done  = busy && (slave_ready_i || expired);
    assign timed_out = busy && !slave_ready_i && expired;
    assign resp_rd   = slave_ready_i ? slave_rd_i : ERR_RDATA;

    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .clear    (!busy),
        .enable   (busy && !slave_ready_i),
        .expired  (expired)
    );

    // Grant the bus from IDLE (round-robin on contention) and release it on completion;
    // the pointer always moves to favour the master that was not just granted.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state     <= IDLE;
            favour_m1 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req_i && m1_req_i) begin
                        state     <= favour_m1 ? BUSY_M1 : BUSY_M0;
                        favour_m1 <= !favour_m1;
                    end else if (m0_req_i) begin
                        state     <= BUSY_M0;
                        favour_m1 <= 1'b1;
                    end else if (m1_req_i) begin
                        state     <= BUSY_M1;
                        favour_m1 <= 1'b0;
                    end
                end
                BUSY_M0, BUSY_M1: begin
                    if (txn_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign grant_o     = {state == BUSY_M1, state == BUSY_M0};
    assign slave_req_o = busy;

    assign slave_we_o   = (state == BUSY_M1) ? m1_we_i   : m0_we_i;
    assign slave_be_o   = (state == BUSY_M1) ? m1_be_i   : m0_be_i;
    assign slave_addr_o = (state == BUSY_M1) ? m1_addr_i : m0_addr_i;
    assign slave_wd_o   = (state == BUSY_M1) ? m1_wd_i   : m0_wd_i;

    assign m0_ready_o = (state == BUSY_M0) && txn_done;
    assign m1_ready_o = (state == BUSY_M1) && txn_done;
    assign m0_err_o   = (state == BUSY_M0) && timed_out;
    assign m1_err_o   = (state == BUSY_M1) && timed_out;
    assign m0_rd_o    = m0_ready_o ? resp_rd : 32'd0;
    assign m1_rd_o    = m1_ready_o ? resp_rd : 32'd0;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter with a short watchdog timeout.
module tb_data_bus_arbiter;

    logic        clk_i;
    logic        resetn_i;
    logic        m0_req_i, m1_req_i;
    logic        m0_we_i, m1_we_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic [31:0] m0_addr_i, m1_addr_i;
    logic [31:0] m0_wd_i, m1_wd_i;
    logic [31:0] m0_rd_o, m1_rd_o;
    logic        m0_ready_o, m1_ready_o;
    logic        m0_err_o, m1_err_o;
    logic        slave_req_o, slave_we_o;
    logic [3:0]  slave_be_o;
    logic [31:0] slave_addr_o, slave_wd_o;
    logic [31:0] slave_rd_i;
    logic        slave_ready_i;
    logic [1:0]  grant_o;

    int checks;
    int failures;

    data_bus_arbiter #(
        .TIMEOUT_CYCLES(8),
        .ERR_RDATA     (32'hDEAD_BEEF)
    ) dut (
        .clk_i        (clk_i),
        .resetn_i     (resetn_i),
        .m0_req_i     (m0_req_i),
        .m0_we_i      (m0_we_i),
        .m0_be_i      (m0_be_i),
        .m0_addr_i    (m0_addr_i),
        .m0_wd_i      (m0_wd_i),
        .m0_rd_o      (m0_rd_o),
        .m0_ready_o   (m0_ready_o),
        .m0_err_o     (m0_err_o),
        .m1_req_i     (m1_req_i),
        .m1_we_i      (m1_we_i),
        .m1_be_i      (m1_be_i),
        .m1_addr_i    (m1_addr_i),
        .m1_wd_i      (m1_wd_i),
        .m1_rd_o      (m1_rd_o),
        .m1_ready_o   (m1_ready_o),
        .m1_err_o     (m1_err_o),
        .slave_req_o  (slave_req_o),
        .slave_we_o   (slave_we_o),
        .slave_be_o   (slave_be_o),
        .slave_addr_o (slave_addr_o),
        .slave_wd_o   (slave_wd_o),
        .slave_rd_i   (slave_rd_i),
        .slave_ready_i(slave_ready_i),
        .grant_o      (grant_o)
    );

    // Free-running 10 ns clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic applyStimulus(input int m, input logic req, input logic we,
                                 input logic [3:0] be, input logic [31:0] addr,
                                 input logic [31:0] wd);
        if (m == 0) begin
            m0_req_i = req; m0_we_i = we; m0_be_i = be; m0_addr_i = addr; m0_wd_i = wd;
        end else begin
            m1_req_i = req; m1_we_i = we; m1_be_i = be; m1_addr_i = addr; m1_wd_i = wd;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Linear sequence of directed steps.
    initial begin
        checks = 0;
        failures = 0;
        resetn_i = 1'b0;
        slave_ready_i = 1'b0;
        slave_rd_i = 32'd0;
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);

        // Reset state
        #1;
        checkOutput("rst_slave_req", 32'(slave_req_o), 32'd0);
        checkOutput("rst_grant",     32'(grant_o),     32'd0);
        checkOutput("rst_m0_ready",  32'(m0_ready_o),  32'd0);
        checkOutput("rst_m1_ready",  32'(m1_ready_o),  32'd0);
        checkOutput("rst_m0_rd",     m0_rd_o,          32'd0);
        repeat (2) tick();
        resetn_i = 1'b1;

        // Lone m0 read, slave answers one cycle after slave_req_o
        $display("[TB] single m0 read");
        applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h100, 32'd0);
        tick();
        checkOutput("rd_slave_req", 32'(slave_req_o), 32'd1);
        checkOutput("rd_grant",     32'(grant_o),     32'd1);
        checkOutput("rd_addr",      slave_addr_o,     32'h100);
        checkOutput("rd_early_rdy", 32'(m0_ready_o),  32'd0);
        tick();
        slave_ready_i = 1'b1;
        slave_rd_i = 32'h1234_5678;
        #1;
        checkOutput("rd_m0_ready", 32'(m0_ready_o), 32'd1);
        checkOutput("rd_m0_rd",    m0_rd_o,         32'h1234_5678);
        checkOutput("rd_m0_err",   32'(m0_err_o),   32'd0);
        checkOutput("rd_m1_ready", 32'(m1_ready_o), 32'd0);
        checkOutput("rd_m1_rd",    m1_rd_o,         32'd0);
        applyStimulus(0, 1'b0, 1'b0, 4'hF, 32'h100, 32'd0);
        tick();
        slave_ready_i = 1'b0;
        #1;
        checkOutput("rd_idle_grant", 32'(grant_o),     32'd0);
        checkOutput("rd_idle_req",   32'(slave_req_o), 32'd0);
        checkOutput("rd_idle_rdy",   32'(m0_ready_o),  32'd0);

        // Fresh reset, then both masters contend with a always-ready slave
        $display("[TB] round robin");
        resetn_i = 1'b0;
        tick();
        resetn_i = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'd0);
        applyStimulus(1, 1'b1, 1'b0, 4'hF, 32'h20, 32'd0);
        slave_ready_i = 1'b1;
        slave_rd_i = 32'h0000_1111;
        tick();
        checkOutput("rr1_grant",    32'(grant_o),    32'b01);
        checkOutput("rr1_m0_ready", 32'(m0_ready_o), 32'd1);
        checkOutput("rr1_m1_ready", 32'(m1_ready_o), 32'd0);
        tick();
        checkOutput("rr2_grant",    32'(grant_o),    32'b00);
        tick();
        checkOutput("rr3_grant",    32'(grant_o),    32'b10);
        checkOutput("rr3_addr",     slave_addr_o,    32'h20);
        checkOutput("rr3_m1_ready", 32'(m1_ready_o), 32'd1);
        checkOutput("rr3_m1_rd",    m1_rd_o,         32'h0000_1111);
        tick();
        checkOutput("rr4_grant",    32'(grant_o),    32'b00);
        tick();
        checkOutput("rr5_grant",    32'(grant_o),    32'b01);
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        tick();
        slave_ready_i = 1'b0;

        // m1 write: fields forwarded unchanged
        $display("[TB] m1 write");
        applyStimulus(1, 1'b1, 1'b1, 4'b0011, 32'h204, 32'hAABB_CCDD);
        tick();
        checkOutput("wr_grant", 32'(grant_o),    32'b10);
        checkOutput("wr_we",    32'(slave_we_o), 32'd1);
        checkOutput("wr_be",    32'(slave_be_o), 32'h3);
        checkOutput("wr_addr",  slave_addr_o,    32'h204);
        checkOutput("wr_wd",    slave_wd_o,      32'hAABB_CCDD);
        checkOutput("wr_early", 32'(m1_ready_o), 32'd0);
        slave_ready_i = 1'b1;
        #1;
        checkOutput("wr_m1_ready", 32'(m1_ready_o), 32'd1);
        checkOutput("wr_m1_err",   32'(m1_err_o),   32'd0);
        checkOutput("wr_m0_ready", 32'(m0_ready_o), 32'd0);
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        tick();
        slave_ready_i = 1'b0;

        // Slave never answers: timeout in the 8th busy cycle
        $display("[TB] timeout");
        applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h300, 32'd0);
        tick();
        checkOutput("to_c1_ready", 32'(m0_ready_o), 32'd0);
        for (int c = 2; c <= 7; c++) begin
            tick();
            checkOutput($sformatf("to_c%0d_ready", c), 32'(m0_ready_o), 32'd0);
        end
        tick();
        checkOutput("to_c8_ready", 32'(m0_ready_o), 32'd1);
        checkOutput("to_c8_err",   32'(m0_err_o),   32'd1);
        checkOutput("to_c8_rd",    m0_rd_o,         32'hDEAD_BEEF);
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        tick();
        checkOutput("to_idle_req", 32'(slave_req_o), 32'd0);
        checkOutput("to_idle_err", 32'(m0_err_o),    32'd0);

        // Slave answers exactly in the timeout cycle: real data, no error
        $display("[TB] ready on timeout cycle");
        applyStimulus(1, 1'b1, 1'b0, 4'hF, 32'h400, 32'd0);
        repeat (8) tick();
        checkOutput("tr_grant", 32'(grant_o), 32'b10);
        slave_ready_i = 1'b1;
        slave_rd_i = 32'hCAFE_F00D;
        #1;
        checkOutput("tr_m1_ready", 32'(m1_ready_o), 32'd1);
        checkOutput("tr_m1_err",   32'(m1_err_o),   32'd0);
        checkOutput("tr_m1_rd",    m1_rd_o,         32'hCAFE_F00D);
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        tick();
        slave_ready_i = 1'b0;

        // Reset in the middle of a BUSY_M1 transaction
        $display("[TB] reset mid transaction");
        applyStimulus(1, 1'b1, 1'b0, 4'hF, 32'h500, 32'd0);
        tick();
        checkOutput("mr_busy_grant", 32'(grant_o), 32'b10);
        resetn_i = 1'b0;
        slave_ready_i = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h600, 32'd0);
        #1;
        checkOutput("mr_slave_req", 32'(slave_req_o), 32'd0);
        checkOutput("mr_grant",     32'(grant_o),     32'd0);
        checkOutput("mr_m1_ready",  32'(m1_ready_o),  32'd0);
        checkOutput("mr_m0_ready",  32'(m0_ready_o),  32'd0);
        tick();
        checkOutput("mr_held_grant", 32'(grant_o), 32'd0);
        resetn_i = 1'b1;
        #1;
        checkOutput("mr_rel_grant", 32'(grant_o), 32'd0);
        tick();
        checkOutput("mr_m0_wins", 32'(grant_o), 32'b01);
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
